// File: rtl/id_ex_skid_reg.sv
// Decode-to-execute pipeline register with a 2-entry skid buffer.
// in_ready is registered; flush empties the stage and stall_cnt tracks back-pressure.
module id_ex_skid_reg #(
  parameter int WIDTH = 220
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [31:0]      out_pc,
  input  logic             flush,
  output logic [31:0]      stall_cnt
);

  // State encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic             r_main_valid;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;
  logic [31:0]      r_stall_cnt;

  logic       w_in_fire;
  logic       w_out_fire;
  logic       w_stall;
  logic [1:0] w_state;

  assign in_ready   = ~r_skid_valid;
  assign out_valid  = r_main_valid;
  assign out_data   = r_main_data;
  assign out_pc     = r_main_data[31:0];
  assign stall_cnt  = r_stall_cnt;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_main_valid & out_ready;
  assign w_stall    = r_main_valid & ~out_ready & ~flush;
  assign w_state    = {r_main_valid, r_skid_valid};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: the data registers are cleared here only because the reset
      // state is defined to be all-zero; a plain datapath could skip this.
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_data  <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;

      if (flush) begin
        // A same-cycle in_fire is dropped; decode still sees it as accepted.
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else begin
        case (w_state)
          ST_EMPTY: begin
            if (w_in_fire) begin
              r_main_valid <= 1'b1;
              r_main_data  <= in_data;
            end
          end
          ST_BUSY: begin
            if (w_in_fire && w_out_fire) begin
              r_main_data <= in_data;
            end else if (w_in_fire) begin
              r_skid_valid <= 1'b1;
              r_skid_data  <= in_data;
            end else if (w_out_fire) begin
              r_main_valid <= 1'b0;
            end
          end
          ST_FULL: begin
            if (w_out_fire) begin
              r_main_data  <= r_skid_data;
              r_skid_valid <= 1'b0;
            end
          end
          default: begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  a_no_skid_without_main : assert property (
    @(posedge clk) disable iff (!resetn) !(!r_main_valid && r_skid_valid)
  );

endmodule

// File: doc/id_ex_skid_reg.md
Name: id_ex_skid_reg

Overview:
- Decode-to-execute pipeline register between the decode stage and the execute-side bundle interpreter.
- Carries the packed ID/EX bundle under a valid/ready handshake, with a 2-entry skid buffer so in_ready is a registered signal.
- Supports flush on taken jump/branch or exception, and counts back-pressure stall cycles.

Parameters:
WIDTH, 220, bundle width; packing MSB→LSB is {inst[31:0], A_data[31:0], B_data[31:0], control_data[53:0], alucontrol_data[37:0], PC[31:0]}

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  synchronous reset, active-low
in_valid  in  1  decode offers a bundle
in_ready  out  1  this stage accepts; registered, equals ~skid_valid
in_data  in  WIDTH  bundle from decode
out_valid  out  1  bundle valid toward execute
out_ready  in  1  execute consumes
out_data  out  WIDTH  bundle toward execute (main register)
out_pc  out  32  out_data[31:0]
flush  in  1  discard all held and incoming bundles
stall_cnt  out  32  cycles with out_valid & ~out_ready

Behaviour:
- Handshake signals:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
  - in_valid and out_ready may toggle freely.
  - in_data is sampled only on in_fire.
- Storage:
  - main (valid bit, data)
  - skid (valid bit, data)
  - out_valid = main_valid; out_data = main_data
- Reset (resetn=0 at a clock edge):
  - main_valid = skid_valid = 0, main_data = skid_data = 0, stall_cnt = 0.
  - Resulting outputs: in_ready = 1, out_valid = 0.
  - Reset overrides flush and any in-flight transfer.
- States (derived from the valid bits):
  - EMPTY: main_valid=0, skid_valid=0
  - BUSY: main_valid=1, skid_valid=0
  - FULL: main_valid=1, skid_valid=1
  - main_valid=0 with skid_valid=1 is illegal and must never occur (assertion).
- Transitions, no flush:
  - EMPTY: in_fire → BUSY, main ← in_data. Otherwise stay EMPTY.
  - BUSY, in_fire & out_fire → BUSY, main ← in_data.
  - BUSY, in_fire & ~out_fire → FULL, skid ← in_data, main held.
  - BUSY, ~in_fire & out_fire → EMPTY.
  - BUSY, neither → hold.
  - FULL: in_ready=0, so no in_fire is possible.
  - FULL, out_fire → BUSY, main ← skid_data, skid_valid ← 0.
  - FULL, ~out_fire → hold.
- Flush (flush=1, resetn=1):
  - Next state is EMPTY.
  - A same-cycle in_fire is discarded; in_ready is still 1 that cycle, so decode treats it as consumed.
  - A same-cycle out_fire still counts as delivered.
  - Data registers are not required to clear.
  - stall_cnt is not affected.
- Timing:
  - Latency: in_fire at edge N → out_valid=1 with that data after edge N.
  - Throughput: 1 bundle/cycle while out_ready=1.
  - Order: strictly FIFO. No bundle is duplicated or dropped except by flush.
- Data stability: while out_valid=1 and out_ready=0, out_data is held constant.
- stall_cnt:
  - +1 on each edge where out_valid & ~out_ready & ~flush.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by reset.
- out_data contents while out_valid=0 are don't-care and are not checked.

Test Plan:
- Reset: resetn=0 for 2 cycles with in_valid=1, in_data=220'h5 → in_ready=1, out_valid=0, stall_cnt=0, nothing captured.
- Streaming: out_ready=1; send 4 bundles with PC=0x00400000, 0x04, 0x08, 0x0C back-to-back → out_pc shows the same sequence one cycle later, in_ready stays 1, stall_cnt=0.
- Back-pressure:
  - Stimulus: out_ready=0; send PC 0x10, 0x14, 0x18.
  - Capture: 0x10 lands in main, 0x14 in skid, then in_ready=0 and 0x18 is held by decode.
  - Drain: raise out_ready → outputs 0x10, 0x14, 0x18 in order.
  - stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
- Flush while FULL: flush=1 with in_valid=1 (PC 0x20) → next cycle out_valid=0, in_ready=1; 0x20 never appears on the output; stall_cnt unchanged that cycle.
- Saturation and reset mid-operation: force stall_cnt near 32'hFFFF_FFFE, stall 3 cycles → holds 32'hFFFF_FFFF. Then assert resetn=0 while FULL → EMPTY and stall_cnt=0 next cycle.
